parity_frame_checker: RTL and testbench

PARITY_FRAME_CHECKER -- requirements
Module: parity_frame_checker

---
 rtl/parity_frame_checker.sv | 131 +++++++++++++
 tb/tb_parity_frame_checker.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_frame_checker.sv
// Serial frame receiver: start bit, four payload bits LSB first, even parity
// over the payload, then a stop bit. Reports good frames, parity errors and
// framing errors as registered one-cycle pulses and keeps a saturating error
// count.
module parity_frame_checker #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  output logic             done,
  output logic [3:0]       data_out,
  output logic             parity_err,
  output logic             framing_err,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PAR,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       payload_q, payload_d;
  logic             parity_q, parity_d;
  logic             done_q, done_d;
  logic             parityErr_q, parityErr_d;
  logic             framingErr_q, framingErr_d;
  logic [3:0]       dataOut_q, dataOut_d;
  logic [CNT_W-1:0] errCnt_q, errCnt_d;

  // Register every piece of state; reset wins over any frame activity.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= 2'd0;
      payload_q    <= 4'd0;
      parity_q     <= 1'b0;
      done_q       <= 1'b0;
      parityErr_q  <= 1'b0;
      framingErr_q <= 1'b0;
      dataOut_q    <= 4'd0;
      errCnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      payload_q    <= payload_d;
      parity_q     <= parity_d;
      done_q       <= done_d;
      parityErr_q  <= parityErr_d;
      framingErr_q <= framingErr_d;
      dataOut_q    <= dataOut_d;
      errCnt_q     <= errCnt_d;
    end
  end

  // Walk the frame bit by bit and decide the status pulse when the stop bit arrives.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    payload_d    = payload_q;
    parity_d     = parity_q;
    done_d       = 1'b0;
    parityErr_d  = 1'b0;
    framingErr_d = 1'b0;
    dataOut_d    = dataOut_q;
    errCnt_d     = errCnt_q;

    case (state_q)
      IDLE: begin
        if (!in) begin
          state_d = DATA;
          idx_d   = 2'd0;
        end
      end
      DATA: begin
        payload_d[idx_q] = in;
        if (idx_q == 2'd3) begin
          state_d = PAR;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      PAR: begin
        parity_d = in;
        state_d  = STOP;
      end
      STOP: begin
        if (in) begin
          // A high stop bit returns straight to IDLE so the next start bit
          // can follow without any idle gap.
          state_d = IDLE;
          if ((^payload_q ^ parity_q) == 1'b0) begin
            done_d    = 1'b1;
            dataOut_d = payload_q;
          end else begin
            parityErr_d = 1'b1;
          end
        end else begin
          // The line is stuck low; wait for it to go high before trusting a
          // new start bit.
          framingErr_d = 1'b1;
          state_d      = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (in) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if ((parityErr_d || framingErr_d) && (errCnt_q != {CNT_W{1'b1}})) begin
      errCnt_d = errCnt_q + 1'b1;
    end
  end

  assign done        = done_q;
  assign data_out    = dataOut_q;
  assign parity_err  = parityErr_q;
  assign framing_err = framingErr_q;
  assign err_cnt     = errCnt_q;

endmodule

// File: tb/tb_parity_frame_checker.sv
// Directed bench for parity_frame_checker: good, parity-bad and framing-bad
// frames, back-to-back traffic, counter saturation and reset mid-frame.
module tb_parity_frame_checker;

  localparam int CNT_W = 8;

  logic             clk;
  logic             reset;
  logic             in;
  logic             done;
  logic [3:0]       data_out;
  logic             parity_err;
  logic             framing_err;
  logic [CNT_W-1:0] err_cnt;

  int assertCount;
  int failCount;

  parity_frame_checker #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in          (in),
    .done        (done),
    .data_out    (data_out),
    .parity_err  (parity_err),
    .framing_err (framing_err),
    .err_cnt     (err_cnt)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one bit, let the edge take it, then settle 1 ns past the edge.
  task automatic sendBit(input logic b);
    in = b;
    @(posedge clk);
    #1;
  endtask

  // Send one frame; counts any status pulse seen before the stop-bit cycle.
  task automatic sendFrame(input logic [3:0] d, input logic par, input logic stop,
                           output int early);
    logic [6:0] bits;
    bits  = {stop, par, d[3], d[2], d[1], d[0], 1'b0};
    early = 0;
    for (int i = 0; i < 7; i++) begin
      sendBit(bits[i]);
      if (i < 6 && (done || parity_err || framing_err)) early++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    assertCount++;
    if ({done, parity_err, framing_err} !== 3'b000) begin
      failCount++;
      $display("[TB] FAIL reset_pulses: got %b expected 000", {done, parity_err, framing_err});
    end
    assertCount++;
    if (data_out !== 4'h0) begin
      failCount++;
      $display("[TB] FAIL reset_data: got %h expected 0", data_out);
    end
    assertCount++;
    if (err_cnt !== 8'd0) begin
      failCount++;
      $display("[TB] FAIL reset_cnt: got %0d expected 0", err_cnt);
    end
    reset = 1'b0;
    sendBit(1'b1);
  endtask

  task automatic test_good_frame();
    int early;
    sendFrame(4'hB, 1'b1, 1'b1, early);
    assertCount++;
    if (early !== 0) begin
      failCount++;
      $display("[TB] FAIL good_early: got %0d early pulses expected 0", early);
    end
    assertCount++;
    if ({done, parity_err, framing_err} !== 3'b100) begin
      failCount++;
      $display("[TB] FAIL good_pulse: got %b expected 100", {done, parity_err, framing_err});
    end
    assertCount++;
    if (data_out !== 4'hB) begin
      failCount++;
      $display("[TB] FAIL good_data: got %h expected b", data_out);
    end
    sendBit(1'b1);
    assertCount++;
    if (done !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL good_one_cycle: got done=%b expected 0", done);
    end
    assertCount++;
    if (err_cnt !== 8'd0 || data_out !== 4'hB) begin
      failCount++;
      $display("[TB] FAIL good_hold: got cnt=%0d data=%h expected cnt=0 data=b", err_cnt, data_out);
    end
  endtask

  task automatic test_parity_error();
    int early;
    sendFrame(4'hB, 1'b0, 1'b1, early);
    assertCount++;
    if (early !== 0) begin
      failCount++;
      $display("[TB] FAIL par_early: got %0d early pulses expected 0", early);
    end
    assertCount++;
    if ({done, parity_err, framing_err} !== 3'b010) begin
      failCount++;
      $display("[TB] FAIL par_pulse: got %b expected 010", {done, parity_err, framing_err});
    end
    assertCount++;
    if (data_out !== 4'hB) begin
      failCount++;
      $display("[TB] FAIL par_data: got %h expected b", data_out);
    end
    sendBit(1'b1);
    assertCount++;
    if (parity_err !== 1'b0 || err_cnt !== 8'd1) begin
      failCount++;
      $display("[TB] FAIL par_after: got pe=%b cnt=%0d expected pe=0 cnt=1", parity_err, err_cnt);
    end
  endtask

  task automatic test_framing_error();
    int early;
    int quiet;
    sendFrame(4'h0, 1'b0, 1'b0, early);
    assertCount++;
    if (early !== 0 || {done, parity_err, framing_err} !== 3'b001) begin
      failCount++;
      $display("[TB] FAIL frm_pulse: got early=%0d pulses=%b expected early=0 pulses=001",
               early, {done, parity_err, framing_err});
    end
    quiet = 0;
    for (int i = 0; i < 5; i++) begin
      sendBit(1'b0);
      if (done || parity_err || framing_err) quiet++;
    end
    assertCount++;
    if (quiet !== 0) begin
      failCount++;
      $display("[TB] FAIL frm_low_hold: got %0d pulses expected 0", quiet);
    end
    assertCount++;
    if (err_cnt !== 8'd2 || data_out !== 4'hB) begin
      failCount++;
      $display("[TB] FAIL frm_state: got cnt=%0d data=%h expected cnt=2 data=b", err_cnt, data_out);
    end
    sendBit(1'b1);
    sendFrame(4'h2, 1'b1, 1'b1, early);
    assertCount++;
    if (early !== 0 || done !== 1'b1 || data_out !== 4'h2) begin
      failCount++;
      $display("[TB] FAIL frm_recover: got early=%0d done=%b data=%h expected early=0 done=1 data=2",
               early, done, data_out);
    end
    sendBit(1'b1);
  endtask

  task automatic test_back_to_back();
    int early;
    sendFrame(4'hB, 1'b1, 1'b1, early);
    assertCount++;
    if (early !== 0 || done !== 1'b1 || data_out !== 4'hB) begin
      failCount++;
      $display("[TB] FAIL b2b_first: got early=%0d done=%b data=%h expected early=0 done=1 data=b",
               early, done, data_out);
    end
    sendFrame(4'h2, 1'b1, 1'b1, early);
    assertCount++;
    if (early !== 0 || done !== 1'b1 || data_out !== 4'h2) begin
      failCount++;
      $display("[TB] FAIL b2b_second: got early=%0d done=%b data=%h expected early=0 done=1 data=2",
               early, done, data_out);
    end
    sendBit(1'b1);
  endtask

  task automatic test_saturation();
    int early;
    int missed;
    missed = 0;
    for (int f = 0; f < 300; f++) begin
      sendFrame(4'hB, 1'b0, 1'b1, early);
      if (early != 0 || parity_err !== 1'b1) missed++;
      if (f == 99) begin
        assertCount++;
        if (err_cnt !== 8'd102) begin
          failCount++;
          $display("[TB] FAIL sat_mid: got %0d expected 102", err_cnt);
        end
      end
    end
    assertCount++;
    if (missed !== 0) begin
      failCount++;
      $display("[TB] FAIL sat_pulses: got %0d bad frames expected 0", missed);
    end
    sendBit(1'b1);
    assertCount++;
    if (err_cnt !== 8'd255) begin
      failCount++;
      $display("[TB] FAIL sat_full: got %0d expected 255", err_cnt);
    end
    sendFrame(4'hB, 1'b0, 1'b1, early);
    sendBit(1'b1);
    assertCount++;
    if (err_cnt !== 8'd255) begin
      failCount++;
      $display("[TB] FAIL sat_hold: got %0d expected 255", err_cnt);
    end
  endtask

  task automatic test_reset_midframe();
    int early;
    int stray;
    sendBit(1'b0);
    sendBit(1'b1);
    sendBit(1'b1);
    reset = 1'b1;
    sendBit(1'b0);
    reset = 1'b0;
    assertCount++;
    if ({done, parity_err, framing_err} !== 3'b000 || data_out !== 4'h0 || err_cnt !== 8'd0) begin
      failCount++;
      $display("[TB] FAIL midrst_clear: got pulses=%b data=%h cnt=%0d expected 000 0 0",
               {done, parity_err, framing_err}, data_out, err_cnt);
    end
    stray = 0;
    for (int i = 0; i < 3; i++) begin
      sendBit(1'b1);
      if (done || parity_err || framing_err) stray++;
    end
    assertCount++;
    if (stray !== 0) begin
      failCount++;
      $display("[TB] FAIL midrst_tail: got %0d pulses expected 0", stray);
    end
    sendFrame(4'h2, 1'b1, 1'b1, early);
    assertCount++;
    if (early !== 0 || done !== 1'b1 || data_out !== 4'h2 || err_cnt !== 8'd0) begin
      failCount++;
      $display("[TB] FAIL midrst_next: got early=%0d done=%b data=%h cnt=%0d expected 0 1 2 0",
               early, done, data_out, err_cnt);
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    assertCount = 0;
    failCount   = 0;
    reset       = 1'b1;
    in          = 1'b1;
    test_reset();
    test_good_frame();
    test_parity_error();
    test_framing_error();
    test_back_to_back();
    test_saturation();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
